traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_pkg.sv | 26 ++
 rtl/tl_timer.sv | 36 +++
 rtl/traffic_light_ctrl.sv | 155 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - state enum, light encodings and duration helper for traffic_light_ctrl
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } tl_state_e;

    // Per-approach {red,yellow,green}
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    function automatic int max_dur(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tl_timer.sv
// rtl/tl_timer.sv - loadable down-counter with zero flag; holds at zero until reloaded
module tl_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - multi-approach traffic light sequencer with pedestrian walk and night flash
module traffic_light_ctrl #(
    parameter int N_DIR    = 2,
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 2,
    parameter int PED_T    = 4,
    parameter int FLASH_T  = 3,
    parameter int CNT_W    = 8,
    localparam int DIR_W   = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               night,
    input  logic [N_DIR-1:0]   ped_req,
    output logic [3*N_DIR-1:0] light,
    output logic [N_DIR-1:0]   ped_walk,
    output logic [DIR_W-1:0]   cur_dir
);
    import traffic_light_pkg::*;

    localparam int MAX_T = max_dur(GREEN_T, YELLOW_T, ALLRED_T, FLASH_T);

    if (N_DIR < 2 || N_DIR > 4 || GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 ||
        FLASH_T < 1 || PED_T < 1 || PED_T > GREEN_T || CNT_W < $clog2(MAX_T + 1)) begin : g_param_check
        $error("traffic_light_ctrl: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_T - 1);
    localparam logic [CNT_W-1:0] WALK_MIN = CNT_W'(GREEN_T - PED_T);
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(N_DIR - 1);

    tl_state_e        state_q, state_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [N_DIR-1:0] pend_q, pend_d;
    logic             walk_q, walk_d;
    logic             lit_q, lit_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_zero;
    logic [N_DIR-1:0] dir_onehot;
    logic             walk_on;

    assign dir_onehot = N_DIR'(1) << dir_q;

    tl_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_ALLRED)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    // Requests collect in pend; the served approach's bit is consumed only on its green entry.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        walk_d   = walk_q;
        lit_d    = lit_q;
        pend_d   = pend_q | ped_req;
        tmr_load = 1'b0;
        tmr_val  = T_ALLRED;
        if (tmr_zero) begin
            tmr_load = 1'b1;
            case (state_q)
                ST_ALLRED: begin
                    if (night) begin
                        state_d = ST_FLASH;
                        tmr_val = T_FLASH;
                        lit_d   = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        tmr_val = T_GREEN;
                        walk_d  = |((pend_q | ped_req) & dir_onehot);
                        pend_d  = (pend_q | ped_req) & ~dir_onehot;
                    end
                end
                ST_GREEN: begin
                    state_d = ST_YELLOW;
                    tmr_val = T_YELLOW;
                end
                ST_YELLOW: begin
                    state_d = ST_ALLRED;
                    tmr_val = T_ALLRED;
                    dir_d   = (dir_q == DIR_LAST) ? '0 : dir_q + DIR_W'(1);
                end
                ST_FLASH: begin
                    if (night) begin
                        lit_d   = ~lit_q;
                        tmr_val = T_FLASH;
                    end else begin
                        state_d = ST_ALLRED;
                        tmr_val = T_ALLRED;
                    end
                end
                default: begin
                    state_d = ST_ALLRED;
                    tmr_val = T_ALLRED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ALLRED;
            dir_q   <= '0;
            pend_q  <= '0;
            walk_q  <= 1'b0;
            lit_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            walk_q  <= walk_d;
            lit_q   <= lit_d;
        end
    end

    // Walk covers the first PED_T cycles of green, i.e. while the timer is still high.
    assign walk_on = walk_q && (tmr_cnt >= WALK_MIN);

    always_comb begin
        light    = '0;
        ped_walk = '0;
        for (int i = 0; i < N_DIR; i++) begin
            light[3*i +: 3] = RED;
            case (state_q)
                ST_GREEN: begin
                    if (dir_onehot[i]) begin
                        light[3*i +: 3] = GREEN;
                        ped_walk[i]     = walk_on;
                    end
                end
                ST_YELLOW: begin
                    if (dir_onehot[i]) light[3*i +: 3] = YELLOW;
                end
                ST_FLASH: light[3*i +: 3] = lit_q ? YELLOW : OFF;
                default: light[3*i +: 3] = RED;
            endcase
        end
    end

    assign cur_dir = dir_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - randomized scoreboard bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

    localparam int N_DIR    = 2;
    localparam int GREEN_T  = 8;
    localparam int YELLOW_T = 2;
    localparam int ALLRED_T = 2;
    localparam int PED_T    = 4;
    localparam int FLASH_T  = 3;
    localparam int CNT_W    = 8;
    localparam int DIR_W    = 1;
    localparam int NCYC     = 1500;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               night;
    logic [N_DIR-1:0]   ped_req;
    logic [3*N_DIR-1:0] light;
    logic [N_DIR-1:0]   ped_walk;
    logic [DIR_W-1:0]   cur_dir;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .N_DIR    (N_DIR),
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .PED_T    (PED_T),
        .FLASH_T  (FLASH_T),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .night    (night),
        .ped_req  (ped_req),
        .light    (light),
        .ped_walk (ped_walk),
        .cur_dir  (cur_dir)
    );

    typedef struct packed {
        logic [3*N_DIR-1:0] light;
        logic [N_DIR-1:0]   walk;
        logic [DIR_W-1:0]   dir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: a phase label with the number of cycles still to run in it.
    typedef enum int {P_ALLRED, P_GREEN, P_YELLOW, P_FLASH} phase_e;
    phase_e m_phase;
    int     m_left;
    int     m_dir;
    int     m_walk_left;
    bit     m_lit;
    bit     m_pend[N_DIR];

    task automatic m_reset();
        m_phase     = P_ALLRED;
        m_left      = ALLRED_T;
        m_dir       = 0;
        m_walk_left = 0;
        m_lit       = 1'b1;
        for (int i = 0; i < N_DIR; i++) m_pend[i] = 1'b0;
    endtask

    task automatic m_step(input bit nt, input logic [N_DIR-1:0] pr);
        for (int i = 0; i < N_DIR; i++) if (pr[i]) m_pend[i] = 1'b1;
        if (m_phase == P_GREEN && m_walk_left > 0) m_walk_left--;
        if (m_left > 1) begin
            m_left--;
            return;
        end
        case (m_phase)
            P_ALLRED: begin
                if (nt) begin
                    m_phase = P_FLASH;
                    m_left  = FLASH_T;
                    m_lit   = 1'b1;
                end else begin
                    m_phase        = P_GREEN;
                    m_left         = GREEN_T;
                    m_walk_left    = m_pend[m_dir] ? PED_T : 0;
                    m_pend[m_dir]  = 1'b0;
                end
            end
            P_GREEN: begin
                m_phase = P_YELLOW;
                m_left  = YELLOW_T;
            end
            P_YELLOW: begin
                m_phase = P_ALLRED;
                m_left  = ALLRED_T;
                m_dir   = (m_dir + 1) % N_DIR;
            end
            default: begin
                if (nt) begin
                    m_lit  = !m_lit;
                    m_left = FLASH_T;
                end else begin
                    m_phase = P_ALLRED;
                    m_left  = ALLRED_T;
                end
            end
        endcase
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.light = '0;
        e.walk  = '0;
        e.dir   = DIR_W'(m_dir);
        for (int i = 0; i < N_DIR; i++) begin
            case (m_phase)
                P_GREEN:  e.light[3*i +: 3] = (i == m_dir) ? 3'b001 : 3'b100;
                P_YELLOW: e.light[3*i +: 3] = (i == m_dir) ? 3'b010 : 3'b100;
                P_FLASH:  e.light[3*i +: 3] = m_lit ? 3'b010 : 3'b000;
                default:  e.light[3*i +: 3] = 3'b100;
            endcase
            if (m_phase == P_GREEN && i == m_dir && m_walk_left > 0) e.walk[i] = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("light", 32'(light), 32'(e.light));
                check("ped_walk", 32'(ped_walk), 32'(e.walk));
                check("cur_dir", 32'(cur_dir), 32'(e.dir));
            end
        end
    end

    initial begin
        bit in_rst;
        int rst_hold;
        reset_n  = 1'b0;
        night    = 1'b0;
        ped_req  = '0;
        in_rst   = 1'b1;
        rst_hold = 0;
        m_reset();
        sb.push_back(m_expect());
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        in_rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (!in_rst) m_step(night, ped_req);
            if (!in_rst && c > 40 && $urandom_range(0, 199) == 0) begin
                #1 reset_n = 1'b0;
                in_rst   = 1'b1;
                rst_hold = $urandom_range(1, 3);
                m_reset();
            end
            sb.push_back(m_expect());
            if (in_rst) begin
                if (rst_hold == 0) begin
                    #1 reset_n = 1'b1;
                    in_rst = 1'b0;
                end else begin
                    rst_hold--;
                end
            end
            if (c > 30 && $urandom_range(0, 29) == 0) night = !night;
            for (int i = 0; i < N_DIR; i++) ped_req[i] = ($urandom_range(0, 7) == 0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
